kmap_block: RTL and testbench

KMAP_BLOCK -- requirements
Module: kmap

---
 rtl/kmap_block_if.sv | 25 ++
 rtl/kmap_block.sv | 56 +++++
 tb/tb_kmap_block.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/kmap_block_if.sv
// kmap_block_if
// Groups the minterm request and result signals of kmap_block.
//   master : drives A..D and in_valid, observes F_0..F_2 and out_valid
//   slave  : the evaluator side (kmap_block)
interface kmap_block_if;
    logic A;
    logic B;
    logic C;
    logic D;
    logic in_valid;
    logic F_0;
    logic F_1;
    logic F_2;
    logic out_valid;

    modport master (
        output A, B, C, D, in_valid,
        input  F_0, F_1, F_2, out_valid
    );

    modport slave (
        input  A, B, C, D, in_valid,
        output F_0, F_1, F_2, out_valid
    );
endinterface

// File: rtl/kmap_block.sv
// kmap_block
// Evaluates three fixed 4-input Boolean functions of the minterm index
// m = {A,B,C,D} and registers them with one cycle of latency.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset; clears all outputs
//   bus  : kmap_block_if.slave (A..D, in_valid in; F_0..F_2, out_valid out)
// The F outputs update only on cycles with in_valid high and hold otherwise;
// out_valid is in_valid delayed by one cycle.
module kmap_block (
    input  logic         clk,
    input  logic         rst,
    kmap_block_if.slave  bus
);

    // Truth table of F_1 indexed by m; bits set for m = 5,6,7,8,10,11,13,14,15.
    localparam logic [15:0] F1_MAP = 16'hEDE0;

    logic [3:0] w_m;
    logic       w_f0;
    logic       w_f1;
    logic       w_f2;

    logic       r_f0;
    logic       r_f1;
    logic       r_f2;
    logic       r_out_valid;

    assign w_m  = {bus.A, bus.B, bus.C, bus.D};
    assign w_f0 = ^w_m;
    assign w_f1 = F1_MAP[w_m];
    // Don't-cares m = 1,5,9,13 resolved as 0,0,1,1, giving this minimal cover.
    assign w_f2 = (bus.A ^ bus.C) | (bus.B & bus.C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f0        <= 1'b0;
            r_f1        <= 1'b0;
            r_f2        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_f0 <= w_f0;
                r_f1 <= w_f1;
                r_f2 <= w_f2;
            end
        end
    end

    assign bus.F_0       = r_f0;
    assign bus.F_1       = r_f1;
    assign bus.F_2       = r_f2;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_kmap_block.sv
module tb_kmap_block;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    kmap_block_if bus ();

    kmap_block dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic       v;
        logic [3:0] exp;   // {F_0, F_1, F_2, out_valid}
    } vec_t;

    vec_t vecs[$];

    // Reference model: function definitions by minterm membership.
    function automatic logic ref_f0(input int m);
        int ones;
        ones = 0;
        for (int b = 0; b < 4; b++) ones += (m >> b) & 1;
        return (ones % 2) == 1;
    endfunction

    function automatic logic ref_f1(input int m);
        return m inside {5, 6, 7, 8, 10, 11, 13, 14, 15};
    endfunction

    function automatic logic ref_f2(input int m);
        return m inside {2, 3, 6, 7, 8, 9, 12, 13, 14, 15};
    endfunction

    function automatic logic [3:0] outs();
        return {bus.F_0, bus.F_1, bus.F_2, bus.out_valid};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got F0F1F2V=%b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m, input logic v);
        {bus.A, bus.B, bus.C, bus.D} = m;
        bus.in_valid = v;
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [3:0] m, input logic v);
        @(negedge clk);
        drive(m, v);
        @(posedge clk);
        #1;
    endtask

    logic [2:0] held;
    logic [3:0] m_r;
    logic       v_r;
    logic [3:0] exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(4'd0, 1'b0);
        rst = 1'b1;

        // Reset state, held across clock edges.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), 4'b0000);

        // Release, first cycle idle: nothing valid yet.
        @(negedge clk);
        rst = 1'b0;
        step(4'd7, 1'b0);
        chk("post_reset_idle", outs(), 4'b0000);

        // Directed vectors, expected values taken from the function definitions.
        vecs.push_back('{4'd0,  1'b1, 4'b0001});
        vecs.push_back('{4'd7,  1'b1, 4'b1111});
        vecs.push_back('{4'd9,  1'b1, 4'b0011});
        vecs.push_back('{4'd10, 1'b1, 4'b0101});
        vecs.push_back('{4'd1,  1'b1, 4'b1001});
        vecs.push_back('{4'd5,  1'b1, 4'b0101});
        vecs.push_back('{4'd9,  1'b1, 4'b0011});
        vecs.push_back('{4'd13, 1'b1, 4'b1111});
        vecs.push_back('{4'd8,  1'b1, 4'b1111});
        vecs.push_back('{4'd3,  1'b0, 4'b1110});
        vecs.push_back('{4'd0,  1'b0, 4'b1110});
        vecs.push_back('{4'd4,  1'b1, 4'b1001});
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].m, vecs[i].v);
            chk($sformatf("vec%0d_m%0d", i, vecs[i].m), outs(), vecs[i].exp);
        end

        // Exhaustive back-to-back sweep.
        for (int m = 0; m < 16; m++) begin
            step(4'(m), 1'b1);
            chk($sformatf("sweep_m%0d", m), outs(),
                {ref_f0(m), ref_f1(m), ref_f2(m), 1'b1});
        end
        held = {ref_f0(15), ref_f1(15), ref_f2(15)};

        // Random stream with idle gaps; model tracks held outputs.
        for (int i = 0; i < 300; i++) begin
            m_r = 4'($urandom_range(0, 15));
            v_r = ($urandom_range(0, 3) != 0);
            step(m_r, v_r);
            if (v_r) held = {ref_f0(m_r), ref_f1(m_r), ref_f2(m_r)};
            exp = {held, v_r};
            chk($sformatf("rand%0d_m%0d_v%0d", i, m_r, v_r), outs(), exp);
        end

        // Async reset mid-cycle while outputs are 1/1/1.
        step(4'd8, 1'b1);
        chk("pre_async_rst", outs(), 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_immediate", outs(), 4'b0000);
        @(posedge clk);
        #1;
        chk("async_rst_held", outs(), 4'b0000);

        // Release and first valid minterm.
        @(negedge clk);
        rst = 1'b0;
        step(4'd14, 1'b1);
        chk("release_m14", outs(), 4'b1111);
        step(4'd14, 1'b0);
        chk("release_hold", outs(), 4'b1110);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
